// File: rtl/squeeze_pkg.sv
// Shared types and default geometry for the squeeze weight sequencer.
package squeeze_pkg;
   localparam int ADDR_DEF  = 8;
   localparam int DEPTH_DEF = 256;
   localparam int PIX_W_DEF = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;
endpackage

// File: rtl/seq_addr_counter.sv
// Weight address / pixel counter pair: address wraps at DEPTH-1 and carries into the pixel count.
module seq_addr_counter
   import squeeze_pkg::*;
#(
   parameter int ADDR  = ADDR_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [PIX_W-1:0] last_pix,
   output logic [ADDR-1:0]  addr,
   output logic             addr_wrap,
   output logic             pix_tc
);

   logic [PIX_W-1:0] pix;

   assign addr_wrap = (addr == ADDR'(DEPTH - 1));
   assign pix_tc    = (pix == last_pix);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
         pix  <= '0;
      end else if (clear) begin
         addr <= '0;
         pix  <= '0;
      end else if (enable) begin
         if (addr_wrap) begin
            addr <= '0;
            pix  <= pix + PIX_W'(1);
         end else begin
            addr <= addr + ADDR'(1);
         end
      end
   end

endmodule

// File: rtl/squeeze_weight_sequencer.sv
// Streams DEPTH weight addresses per output pixel to a combinational ROM with ready/valid flow control.
// Optional stall counter output enabled by defining SEQ_STALL_COUNT_EN.
module squeeze_weight_sequencer
   import squeeze_pkg::*;
#(
   parameter int ADDR  = ADDR_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PIX_W-1:0] num_pixels,
   input  logic             mac_ready,
   output logic [ADDR-1:0]  rom_address,
   output logic             w_valid,
   output logic             acc_clear,
   output logic             acc_last,
   output logic             busy,
   output logic             done
`ifdef SEQ_STALL_COUNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   seq_state_t       state, state_next;
   logic             start_accept;
   logic             beat;
   logic             addr_wrap;
   logic             pix_tc;
   logic [PIX_W-1:0] last_pix;
   logic [ADDR-1:0]  addr;

   assign start_accept = (state == IDLE) && start;
   assign w_valid      = (state == RUN);
   assign beat         = w_valid && mac_ready;
   assign rom_address  = addr;
   // Beat qualifiers are gated by w_valid so they read 0 outside RUN.
   assign acc_clear    = w_valid && (addr == '0);
   assign acc_last     = w_valid && addr_wrap;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (num_pixels != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (beat && addr_wrap && pix_tc) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // num_pixels-1 wraps to all-ones when num_pixels is 0, but RUN is never entered then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_pix <= '0;
      end else if (start_accept) begin
         last_pix <= num_pixels - PIX_W'(1);
      end
   end

   seq_addr_counter #(
      .ADDR  (ADDR),
      .DEPTH (DEPTH),
      .PIX_W (PIX_W)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_accept),
      .enable    (beat),
      .last_pix  (last_pix),
      .addr      (addr),
      .addr_wrap (addr_wrap),
      .pix_tc    (pix_tc)
   );

`ifdef SEQ_STALL_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (start_accept) begin
         stall_cycles <= '0;
      end else if (w_valid && !mac_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/squeeze_weight_sequencer.md
SQUEEZE_WEIGHT_SEQUENCER -- requirements
Module: squeeze_weight_sequencer

Interface
REQ-001: Parameter ADDR, default 8, SHALL set the weight ROM address width.
REQ-002: Parameter DEPTH, default 256, SHALL set the weights per kernel pass; legal range 1..2**ADDR.
REQ-003: Parameter PIX_W, default 12, SHALL set the pixel-count width.
REQ-004: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: start  input  1  single-cycle request to begin a layer pass; SHALL be accepted only in IDLE.
REQ-007: num_pixels  input  PIX_W  output pixels to process; SHALL be sampled at start acceptance; 0 means no pixels.
REQ-008: mac_ready  input  1  the MAC array can consume the current weight beat.
REQ-009: rom_address  output  ADDR  address driven to the combinational ROM array.
REQ-010: w_valid  output  1  the ROM outputs at rom_address form a valid beat.
REQ-011: acc_clear  output  1  qualifies the first beat of a pixel (address 0).
REQ-012: acc_last  output  1  qualifies the last beat of a pixel (address DEPTH-1).
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  single-cycle pulse when the pass completes.

Function
REQ-015: FSM states SHALL be IDLE, RUN and DONE.
REQ-016: IDLE->RUN SHALL occur on start with num_pixels != 0; rom_address=0 and w_valid=1 in the first RUN cycle.
REQ-017: IDLE->DONE SHALL occur on start with num_pixels==0; no beat SHALL be issued.
REQ-018: A beat SHALL transfer when w_valid && mac_ready.
REQ-019: While w_valid && !mac_ready, rom_address, acc_clear and acc_last SHALL hold unchanged.
REQ-020: On transfer with rom_address<DEPTH-1, rom_address SHALL increment by 1 in the next cycle.
REQ-021: On transfer with rom_address==DEPTH-1, rom_address SHALL wrap to 0 and the pixel counter SHALL increment.
REQ-022: On transfer of the last beat of pixel num_pixels-1, the FSM SHALL go to DONE; w_valid SHALL be 0 from that cycle on.
REQ-023: DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024: start SHALL be ignored outside IDLE.
REQ-025: With DEPTH==1, acc_clear and acc_last SHALL both be 1 on every beat.
REQ-026: There SHALL be no bubble between beats when mac_ready stays high; throughput is one beat per cycle.

Reset
REQ-027: When rst is asserted, the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-028: Reset values SHALL be: rom_address=0, w_valid=0, acc_clear=0, acc_last=0, busy=0, done=0, and all internal counters 0.
REQ-029: A reset asserted mid-pass SHALL abandon the pass; done SHALL NOT be emitted.

Configuration
REQ-030: Macro SEQ_STALL_COUNT_EN, when defined, SHALL add a 32-bit output stall_cycles.
  - stall_cycles SHALL count cycles with w_valid && !mac_ready.
  - stall_cycles SHALL clear on start acceptance and on reset, and saturate at all-ones.
REQ-031: When SEQ_STALL_COUNT_EN is not defined, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032: A shared package squeeze_pkg SHALL hold the FSM state enum (seq_state_t) and the default ADDR, DEPTH and PIX_W constants.
REQ-033: The address/pixel counter pair SHALL be a sub-module, seq_addr_counter (enable, wrap and terminal-count flags).
REQ-034: The ROM array SHALL stay outside this block; only rom_address connects to it.

Verification
REQ-035: DEPTH=4, num_pixels=2, mac_ready=1 -> addresses 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
  - acc_clear at beats 1 and 5; acc_last at beats 4 and 8.
  - done exactly one cycle after beat 8; busy low the cycle after done.
REQ-036: DEPTH=4, num_pixels=1, mac_ready low for 3 cycles at address 2 -> address held at 2 for 4 cycles; total 7 valid cycles; stall_cycles=3 with SEQ_STALL_COUNT_EN.
REQ-037: start with num_pixels=0 -> no w_valid; done pulses one cycle after start.
REQ-038: rst asserted asynchronously at address 2 of pixel 1 -> outputs at reset values before the next clk edge; no done; a new start then begins at address 0, pixel 0.
REQ-039: start re-pulsed during RUN -> ignored, pass completes with the original num_pixels; DEPTH=1 run -> acc_clear=acc_last=1 on every beat.
